bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
Round-robin arbiter that shares the single system bus between up to NUM_MASTERS bus masters (CPU, DMA, debug port).
- Grants one master at a time and holds the grant until the addressed slave acknowledges, the master withdraws, or a watchdog timeout fires.
- The granted master's address phase drives the slave decoder. The decoder's one-hot select steers the read-data mux back to that master.

Parameters:
- NUM_MASTERS, 3, number of requesting masters (2..8).
- TIMEOUT, 16, maximum BUSY cycles before forced release (1..255); 0 disables the watchdog.
- ID_W, 2, width of gnt_id; must be ≥ clog2(NUM_MASTERS).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_MASTERS  per-master bus request, level; held until the transaction ends.
- ack  input  1  slave transfer-complete strobe for the current transaction.
- grant  output  NUM_MASTERS  one-hot grant, registered.
- gnt_id  output  ID_W  binary index of the granted master; valid while busy=1.
- busy  output  1  bus owned (state BUSY).
- timeout_err  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: grant=0, gnt_id=0, busy=0, timeout_err=0, state=IDLE, wd_cnt=0, rr_ptr=NUM_MASTERS-1 (master 0 has highest priority first).
- Reset mid-transaction: grant drops the cycle after rst is sampled high. There is no err pulse.
- States: IDLE, BUSY, TURN.
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0: select the first asserted req scanning from index rr_ptr+1 upward, wrapping modulo NUM_MASTERS. From the next edge: grant=onehot(sel), gnt_id=sel, busy=1, wd_cnt=0, state=BUSY.
- Latency: req sampled high in cycle t gives grant high in cycle t+1.
- BUSY, every cycle: grant and gnt_id are stable; wd_cnt increments.
- BUSY, ack=1: release at the next edge (grant=0, busy=0), rr_ptr=gnt_id, state=TURN.
- BUSY, req[gnt_id]=0 and ack=0: treated as abort. Release as for ack, rr_ptr=gnt_id, no err.
- BUSY, watchdog: TIMEOUT≠0, ack=0, req still high and wd_cnt==TIMEOUT-1. Release at the next edge, timeout_err=1 for exactly that one cycle, rr_ptr=gnt_id, state=TURN.
  - Grant is therefore high for at most TIMEOUT cycles.
- Precedence within BUSY: ack > abort > timeout. Ack arriving on the final watchdog cycle completes normally with no err.
- TURN: a single bus-turnaround cycle with grant=0 and busy=0. Always goes to IDLE next; requests are not evaluated in TURN.
- Back-to-back grants are therefore separated by 2 idle cycles (TURN + IDLE arbitration cycle).
- ack while IDLE or TURN is ignored.
- Requests from non-granted masters never affect the current grant; there is no preemption.
- Fairness: every continuously-requesting master is granted within NUM_MASTERS-1 foreign transactions.
- Invariants:
  - grant is 0 or one-hot.
  - grant[gnt_id]==1 whenever busy=1.
  - busy==|grant.
  - timeout_err never coincides with grant!=0 in the same cycle.

Test Plan:
- Reset then req=3'b111, ack pulses 2 cycles after each grant: grant sequence 001, 010, 100, 001. gnt_id 0,1,2,0. Exactly 2 zero-grant cycles between grants.
- req=3'b100 only, ack after 3 BUSY cycles: grant=100 for 3 cycles (t+1..t+3), busy tracks grant, rr_ptr=2. A following req=3'b101 grants master 0 first.
- TIMEOUT=4, req=3'b010, ack never: grant=010 for exactly 4 cycles, then grant=0 with timeout_err=1 for 1 cycle. A subsequent req=3'b011 grants master 0.
- Ack and watchdog expiry in the same cycle (TIMEOUT=4, ack on 4th BUSY cycle): normal release, timeout_err stays 0.
- Master 1 drops req mid-transaction (cycle 2 of BUSY, ack=0): grant drops next cycle, no err. Master 2 (still requesting) is granted 2 cycles later.
- rst asserted on cycle 2 of BUSY with req=3'b111: all outputs 0 next cycle. After rst deasserts, master 0 is granted first.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Shared-bus arbitration signals between the requesting masters and the arbiter.
interface bus_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned ID_W        = 2
);
  logic [NUM_MASTERS-1:0] req;
  logic                   ack;
  logic [NUM_MASTERS-1:0] grant;
  logic [ID_W-1:0]        gnt_id;
  logic                   busy;
  logic                   timeout_err;

  // Requester side: drives requests and the slave completion strobe.
  modport master (
    output req, ack,
    input  grant, gnt_id, busy, timeout_err
  );

  // Arbiter side: consumes requests, produces the grant.
  modport slave (
    input  req, ack,
    output grant, gnt_id, busy, timeout_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with grant hold, abort detection, watchdog and a
// single turnaround cycle between owners.
module bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned ID_W        = 2
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  bus
);

  localparam int unsigned WD_W = 8;

  typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;

  state_t                 state, state_n;
  logic [NUM_MASTERS-1:0] grant_q, grant_n;
  logic [ID_W-1:0]        gnt_id_q, gnt_id_n;
  logic [ID_W-1:0]        rr_ptr, rr_ptr_n;
  logic                   busy_q, busy_n;
  logic                   terr_q, terr_n;
  logic [WD_W-1:0]        wd_cnt, wd_cnt_n;

  logic [ID_W-1:0]        sel;
  logic                   found;
  int unsigned            cand;
  logic                   wd_hit;
  logic                   own_req;

  // Round-robin pick: first active request after the last owner, wrapping.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      cand = (32'(rr_ptr) + i) % NUM_MASTERS;
      if (!found && bus.req[cand[ID_W-1:0]]) begin
        sel   = cand[ID_W-1:0];
        found = 1'b1;
      end
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_n  = state;
    grant_n  = grant_q;
    gnt_id_n = gnt_id_q;
    busy_n   = busy_q;
    rr_ptr_n = rr_ptr;
    wd_cnt_n = wd_cnt;
    terr_n   = 1'b0;
    own_req  = bus.req[gnt_id_q];
    wd_hit   = (TIMEOUT != 0) && (wd_cnt == WD_W'(TIMEOUT - 1));

    case (state)
      IDLE: begin
        grant_n = '0;
        busy_n  = 1'b0;
        if (found) begin
          grant_n  = NUM_MASTERS'(1) << sel;
          gnt_id_n = sel;
          busy_n   = 1'b1;
          wd_cnt_n = '0;
          state_n  = BUSY;
        end
      end
      BUSY: begin
        wd_cnt_n = wd_cnt + WD_W'(1);
        // Release priority: ack, then withdrawal, then watchdog.
        if (bus.ack || !own_req || wd_hit) begin
          grant_n  = '0;
          busy_n   = 1'b0;
          rr_ptr_n = gnt_id_q;
          wd_cnt_n = '0;
          terr_n   = !bus.ack && own_req && wd_hit;
          state_n  = TURN;
        end
      end
      TURN: begin
        grant_n = '0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        grant_n = '0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_q  <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
      wd_cnt   <= '0;
      rr_ptr   <= ID_W'(NUM_MASTERS - 1);
    end else begin
      state    <= state_n;
      grant_q  <= grant_n;
      gnt_id_q <= gnt_id_n;
      busy_q   <= busy_n;
      terr_q   <= terr_n;
      wd_cnt   <= wd_cnt_n;
      rr_ptr   <= rr_ptr_n;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.gnt_id      = gnt_id_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

endmodule
